// File: rtl/ifu_pkg.sv
// ifu_pkg: shared state encoding and constants for the instruction fetch unit
package ifu_pkg;
  typedef enum logic {FETCH, HOLD} state_t;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/ifu_npc.sv
// ifu_npc: next fetch address from the instruction in ID and its live branch/jump strobes
module ifu_npc
  import ifu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] id_pc,
  input  logic [25:0] instr_index,
  input  logic        id_valid,
  input  logic        branch,
  input  logic        cmp_out,
  input  logic        j,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc
);
  logic [31:0] seq_pc;
  logic [31:0] slot_pc;
  logic [31:0] br_off;
  assign seq_pc  = pc + 32'd4;
  assign slot_pc = id_pc + 32'd4;
  assign br_off  = {{14{instr_index[15]}}, instr_index[15:0], 2'b00};
  always_comb begin
    next_pc = !id_valid          ? seq_pc :
              jr                 ? jr_target & 32'hFFFF_FFFC :
              j                  ? {slot_pc[31:28], instr_index, 2'b00} :
              (branch && cmp_out) ? slot_pc + br_off :
                                   seq_pc;
  end
endmodule

// File: rtl/ifu.sv
// ifu: PC, IF/ID register and instruction-memory handshake with a one-word stall buffer
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic        cmp_out,
  input  logic        j,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        id_fire
);
  state_t      state, state_nx;
  logic [31:0] pc, ibuf, next_pc;
  logic        park;
  ifu_npc u_npc (
    .pc         (pc),
    .id_pc      (id_pc),
    .instr_index(id_instr[25:0]),
    .id_valid   (id_valid),
    .branch     (branch),
    .cmp_out    (cmp_out),
    .j          (j),
    .jr         (jr),
    .jr_target  (jr_target),
    .next_pc    (next_pc)
  );
  always_comb begin
    id_fire  = !reset && !stall && (state == HOLD || imem_ack);
    park     = !reset && stall && state == FETCH && imem_ack;
    state_nx = id_fire ? FETCH : park ? HOLD : state;
    imem_req = !reset && state == FETCH;
  end
  assign imem_addr = pc;
  assign id_pc8    = id_pc + 32'd8;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ibuf     <= NOP;
      id_instr <= NOP;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (park) ibuf <= imem_rdata;
      if (id_fire) begin
        id_instr <= state == HOLD ? ibuf : imem_rdata;
        id_pc    <= pc;
        id_valid <= 1'b1;
        pc       <= next_pc;
      end
    end
  end
endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit: owns the PC and the IF/ID pipeline register, drives the instruction-memory request handshake, and computes the next fetch address. It consumes the branch decision `cmp_out` produced in ID, together with the decoder's branch/jump strobes for the instruction currently held in ID. MIPS single delay slot: the word fetched after a branch or jump always enters ID, and redirection applies to the fetch after it.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit holds ID (ID register must not change)
- branch  in  1  ID instruction is a conditional branch
- cmp_out  in  1  branch taken, from the ID comparator
- j  in  1  ID instruction is j/jal
- jr  in  1  ID instruction is jr/jalr
- jr_target  in  32  forwarded rs value
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_ack  in  1  imem_rdata valid this cycle
- imem_rdata  in  32  fetched word
- id_instr  out  32  instruction in ID
- id_pc  out  32  PC of id_instr
- id_pc8  out  32  id_pc + 8, link value
- id_valid  out  1  ID holds a real instruction
- id_fire  out  1  ID register loads this cycle; downstream inserts a bubble into EX when low

## Operation
- State machine has two states:
  - FETCH: imem_req=1; imem_addr=pc.
  - HOLD: word buffered; imem_req=0.
- FETCH, imem_ack=0: stay in FETCH; pc and addr stay stable. Once asserted, the request holds until ack.
- FETCH, imem_ack=1, stall=0: load the ID register with {imem_rdata, pc, valid=1}; pc <= next_pc; stay in FETCH.
- FETCH, imem_ack=1, stall=1: buf <= imem_rdata; go to HOLD.
- HOLD, stall=0: load the ID register from buf; pc <= next_pc; go to FETCH.
- HOLD, stall=1: stay in HOLD.
- id_fire is 1 exactly on the ID-load transitions above. Otherwise the ID register holds its contents.
- next_pc is evaluated in the id_fire cycle, from the old ID contents and the live strobes:
  - jr: {jr_target[31:2], 2'b00}
  - else j: {id_pc[31:28]+carry-free from id_pc+4, instr_index, 2'b00}, i.e. {(id_pc+4)[31:28], id_instr[25:0], 2'b00}
  - else branch & cmp_out: id_pc + 4 + (sext(id_instr[15:0]) << 2)
  - else: pc + 4
- Strobe priority is jr > j > branch. When id_valid=0, strobes are ignored.
- All adds wrap modulo 2^32.
- Because next_pc is sampled only in the id_fire cycle, cmp_out/jr_target must be valid in that cycle. The hazard unit enforces this through stall.

## Timing
- Reset values:
  - pc=RESET_PC; state=FETCH
  - imem_req=0 while reset=1
  - id_instr=0, id_pc=0, id_valid=0, id_fire=0
  - buf=0
- Reset mid-request abandons the request; the ack of the abandoned request is ignored in the reset cycle.
- Zero-wait memory (ack in the request cycle) gives one instruction per cycle.
- Latency: request issue to id_instr valid is ack cycle + 1.
- Branch penalty is 0 beyond the delay slot. The target fetch is issued in the cycle after the delay-slot word enters ID.
- stall and ack in the same cycle: the word goes to buf. It never enters ID in a stall cycle.
- imem_addr[1:0] is always 00.

## Structure
- Shared package holds:
  - the state enum {FETCH, HOLD}
  - default RESET_PC
  - NOP = 32'h0000_0000
- One sub-module, `npc`: purely combinational next-PC mux and adders. Inputs: pc, id_pc, id_instr, id_valid, strobes, jr_target. Output: next_pc.

## Test plan
- Reset, then an ack every cycle: imem_addr = 3000, 3004, 3008; id_pc follows one cycle later; id_valid rises in the first ack+1 cycle.
- 2-cycle memory wait (ack low for 2 cycles at 3004): imem_addr stays 3004 for 3 cycles; id_fire=0 for 2 cycles; ID contents unchanged.
- beq in ID at id_pc=3000, imm16=0x0003, cmp_out=1: delay slot 3004 enters ID, then imem_addr=3010. With cmp_out=0, imem_addr=3008.
- j at id_pc=3000 with instr_index=0x0000C10: delay slot 3004 is fetched, then imem_addr=3040. jr with jr_target=32'h0000_3103: imem_addr=3100.
- stall=1 coinciding with ack of 0x2408_0005: state goes to HOLD, imem_req=0, id_instr unchanged. After stall drops, id_instr=2408_0005 and the next request is issued the following cycle.
- reset asserted during an outstanding request: next cycle imem_req=0 and id_valid=0; after release, imem_addr=3000.
